up_sampling_nn: RTL and testbench



---
 rtl/up_sampling_nn_if.sv | 29 ++
 rtl/up_sampling_nn.sv | 202 ++++++++++++++++++++
 tb/tb_up_sampling_nn.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/up_sampling_nn_if.sv
// Stream bundle for the nearest-neighbour up-sampler: pixel input with ready/valid and
// framing markers, plus the registered output stream (which has no backpressure).
interface up_sampling_nn_if #(
    parameter int unsigned DATA_WIDTH = 8
) ();
    logic signed [DATA_WIDTH-1:0] data_i;
    logic                         valid_i;
    logic                         ready_o;
    logic                         sop_i;
    logic                         eop_i;
    logic                         sof_i;
    logic                         eof_i;
    logic signed [DATA_WIDTH-1:0] data_o;
    logic                         data_valid_o;
    logic                         sop_o;
    logic                         eop_o;
    logic                         sof_o;
    logic                         eof_o;

    modport master (
        output data_i, valid_i, sop_i, eop_i, sof_i, eof_i,
        input  ready_o, data_o, data_valid_o, sop_o, eop_o, sof_o, eof_o
    );

    modport slave (
        input  data_i, valid_i, sop_i, eop_i, sof_i, eof_i,
        output ready_o, data_o, data_valid_o, sop_o, eop_o, sof_o, eof_o
    );
endinterface

// File: rtl/up_sampling_nn.sv
// Nearest-neighbour up-sampler: buffers one channel-interleaved line, then replays it as SCALE
// rows with each pixel repeated SCALE times. Define UP_SAMPLING_ERR_EN to add sticky err_o.
module up_sampling_nn #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned STRING_LEN  = 28,
    parameter int unsigned CHANNEL_NUM = 64,
    parameter int unsigned SCALE       = 2
) (
    input  logic               clk,
    input  logic               reset,
    up_sampling_nn_if.slave    bus
`ifdef UP_SAMPLING_ERR_EN
    ,
    output logic               err_o
`endif
);
    localparam int unsigned LineLen = STRING_LEN * CHANNEL_NUM;
    localparam int unsigned AddrW   = (LineLen > 1)     ? $clog2(LineLen)     : 1;
    localparam int unsigned ChW     = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
    localparam int unsigned PixW    = (STRING_LEN > 1)  ? $clog2(STRING_LEN)  : 1;
    localparam int unsigned ScW     = (SCALE > 1)       ? $clog2(SCALE)       : 1;

    localparam logic [AddrW-1:0] LastAddr = AddrW'(LineLen - 1);
    localparam logic [AddrW-1:0] ChStep   = AddrW'(CHANNEL_NUM);
    localparam logic [ChW-1:0]   ChMax    = ChW'(CHANNEL_NUM - 1);
    localparam logic [PixW-1:0]  PixMax   = PixW'(STRING_LEN - 1);
    localparam logic [ScW-1:0]   ScMax    = ScW'(SCALE - 1);

    typedef enum logic {StLoad, StEmit} state_e;

    state_e state_q, state_d;

    logic                  ready;
    logic                  rd_en;
    logic                  wr_en;
    logic                  line_done;
    logic [AddrW-1:0]      wr_cnt_q;
    logic [AddrW-1:0]      wr_addr;
    logic [AddrW-1:0]      rd_addr;
    logic [AddrW-1:0]      base_q;
    logic [ChW-1:0]        ch_q;
    logic [ScW-1:0]        rep_q;
    logic [PixW-1:0]       pix_q;
    logic [ScW-1:0]        row_q;
    logic                  ch_last, rep_last, pix_last, row_last, emit_last;
    logic                  sof_pend_q, eof_pend_q;
    logic                  mk_sop, mk_eop, mk_sof, mk_eof;
    logic                  s1_vld_q, s1_sop_q, s1_eop_q, s1_sof_q, s1_eof_q;

    logic signed [DATA_WIDTH-1:0] mem [LineLen];
    logic signed [DATA_WIDTH-1:0] ram_q;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StLoad;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StLoad: if (wr_en && line_done) state_d = StEmit;
            StEmit: if (emit_last)          state_d = StLoad;
        endcase
    end

    // FSM: outputs
    always_comb begin
        ready       = (state_q == StLoad);
        rd_en       = (state_q == StEmit);
        bus.ready_o = ready;
    end

    assign wr_en     = bus.valid_i && ready;
    assign wr_addr   = bus.sop_i ? '0 : wr_cnt_q;
    assign line_done = (wr_addr == LastAddr);

    assign ch_last   = (ch_q == ChMax);
    assign rep_last  = (rep_q == ScMax);
    assign pix_last  = (pix_q == PixMax);
    assign row_last  = (row_q == ScMax);
    assign emit_last = ch_last && rep_last && pix_last && row_last;
    assign rd_addr   = base_q + AddrW'(ch_q);

    always_comb begin
        mk_sop = (ch_q == '0) && (rep_q == '0) && (pix_q == '0);
        mk_eop = ch_last && rep_last && pix_last;
        mk_sof = mk_sop && (row_q == '0) && sof_pend_q;
        mk_eof = mk_eop && row_last && eof_pend_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt_q <= '0;
        end else if (wr_en) begin
            wr_cnt_q <= line_done ? '0 : wr_addr + AddrW'(1);
        end
    end

    // Flags are cleared on the final read; their markers are already in the pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            sof_pend_q <= 1'b0;
            eof_pend_q <= 1'b0;
        end else if (rd_en && emit_last) begin
            sof_pend_q <= 1'b0;
            eof_pend_q <= 1'b0;
        end else if (wr_en) begin
            if (bus.sof_i) sof_pend_q <= 1'b1;
            if (bus.eof_i) eof_pend_q <= 1'b1;
        end
    end

    // Replay counters, innermost first: channel, horizontal repeat, pixel, output row.
    always_ff @(posedge clk) begin
        if (reset) begin
            ch_q   <= '0;
            rep_q  <= '0;
            pix_q  <= '0;
            row_q  <= '0;
            base_q <= '0;
        end else if (rd_en) begin
            if (!ch_last) begin
                ch_q <= ch_q + ChW'(1);
            end else begin
                ch_q <= '0;
                if (!rep_last) begin
                    rep_q <= rep_q + ScW'(1);
                end else begin
                    rep_q <= '0;
                    if (!pix_last) begin
                        pix_q  <= pix_q + PixW'(1);
                        base_q <= base_q + ChStep;
                    end else begin
                        pix_q  <= '0;
                        base_q <= '0;
                        row_q  <= row_last ? '0 : row_q + ScW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= bus.data_i;
        if (rd_en) ram_q <= mem[rd_addr];
    end

    // Two-stage output pipeline: markers ride alongside the RAM read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld_q         <= 1'b0;
            s1_sop_q         <= 1'b0;
            s1_eop_q         <= 1'b0;
            s1_sof_q         <= 1'b0;
            s1_eof_q         <= 1'b0;
            bus.data_o       <= '0;
            bus.data_valid_o <= 1'b0;
            bus.sop_o        <= 1'b0;
            bus.eop_o        <= 1'b0;
            bus.sof_o        <= 1'b0;
            bus.eof_o        <= 1'b0;
        end else begin
            s1_vld_q         <= rd_en;
            s1_sop_q         <= rd_en && mk_sop;
            s1_eop_q         <= rd_en && mk_eop;
            s1_sof_q         <= rd_en && mk_sof;
            s1_eof_q         <= rd_en && mk_eof;
            bus.data_o       <= s1_vld_q ? ram_q : '0;
            bus.data_valid_o <= s1_vld_q;
            bus.sop_o        <= s1_sop_q;
            bus.eop_o        <= s1_eop_q;
            bus.sof_o        <= s1_sof_q;
            bus.eof_o        <= s1_eof_q;
        end
    end

`ifdef UP_SAMPLING_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (wr_en && ((bus.sop_i && (wr_cnt_q != '0)) ||
                               (bus.eop_i && (wr_cnt_q != LastAddr)) ||
                               (line_done && !bus.eop_i))) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    // Line end is defined by the count; eop_i only feeds the optional checker.
    logic unused_eop;
    assign unused_eop = bus.eop_i;
`endif

endmodule

// File: tb/tb_up_sampling_nn.sv
// Directed bench for up_sampling_nn: SCALE=2 main instance plus SCALE=1 and SCALE=3 instances.
module tb_up_sampling_nn;
    localparam int SL = 4;
    localparam int CH = 2;
    localparam int LL = SL * CH;

    typedef struct {
        logic [7:0] d;
        logic       sop, eop, sof, eof;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       sop, eop, sof, eof;
        int         cyc;
    } out_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    int         cyc = 0;
    logic [7:0] din = '0;
    logic       vld = 1'b0, s_i = 1'b0, e_i = 1'b0, f_i = 1'b0, g_i = 1'b0;
    logic       en1 = 1'b0, en2 = 1'b1, en3 = 1'b0;
    int         checks = 0;
    int         failures = 0;
    int         acc_cyc = 0;
    int         run = 0;
    int         runs[$];
    out_t       q1[$], q2[$], q3[$];
    vec_t       vin[LL];
    vec_t       exp2[4 * LL];
    int         rp[2 * LL] = '{0, 1, 0, 1, 2, 3, 2, 3, 4, 5, 4, 5, 6, 7, 6, 7};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    up_sampling_nn_if #(.DATA_WIDTH(8)) if1 ();
    up_sampling_nn_if #(.DATA_WIDTH(8)) if2 ();
    up_sampling_nn_if #(.DATA_WIDTH(8)) if3 ();

    assign if1.data_i = din; assign if2.data_i = din; assign if3.data_i = din;
    assign if1.sop_i  = s_i; assign if2.sop_i  = s_i; assign if3.sop_i  = s_i;
    assign if1.eop_i  = e_i; assign if2.eop_i  = e_i; assign if3.eop_i  = e_i;
    assign if1.sof_i  = f_i; assign if2.sof_i  = f_i; assign if3.sof_i  = f_i;
    assign if1.eof_i  = g_i; assign if2.eof_i  = g_i; assign if3.eof_i  = g_i;
    assign if1.valid_i = vld & en1;
    assign if2.valid_i = vld & en2;
    assign if3.valid_i = vld & en3;

`ifdef UP_SAMPLING_ERR_EN
    logic err1, err2, err3;
`endif

    up_sampling_nn #(.DATA_WIDTH(8), .STRING_LEN(SL), .CHANNEL_NUM(CH), .SCALE(1)) dut1 (
        .clk(clk), .reset(reset), .bus(if1)
`ifdef UP_SAMPLING_ERR_EN
        , .err_o(err1)
`endif
    );
    up_sampling_nn #(.DATA_WIDTH(8), .STRING_LEN(SL), .CHANNEL_NUM(CH), .SCALE(2)) dut2 (
        .clk(clk), .reset(reset), .bus(if2)
`ifdef UP_SAMPLING_ERR_EN
        , .err_o(err2)
`endif
    );
    up_sampling_nn #(.DATA_WIDTH(8), .STRING_LEN(SL), .CHANNEL_NUM(CH), .SCALE(3)) dut3 (
        .clk(clk), .reset(reset), .bus(if3)
`ifdef UP_SAMPLING_ERR_EN
        , .err_o(err3)
`endif
    );

    // Output capture and ready-low run lengths, sampled away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (if1.data_valid_o)
                q1.push_back('{if1.data_o, if1.sop_o, if1.eop_o, if1.sof_o, if1.eof_o, cyc});
            if (if2.data_valid_o)
                q2.push_back('{if2.data_o, if2.sop_o, if2.eop_o, if2.sof_o, if2.eof_o, cyc});
            if (if3.data_valid_o)
                q3.push_back('{if3.data_o, if3.sop_o, if3.eop_o, if3.sof_o, if3.eof_o, cyc});
            if (!if2.ready_o) begin
                run <= run + 1;
            end else if (run != 0) begin
                runs.push_back(run);
                run <= 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic cmp_out(input string name, input out_t a, input vec_t e);
        chk(name, {20'h0, a.d, a.sop, a.eop, a.sof, a.eof},
                  {20'h0, e.d, e.sop, e.eop, e.sof, e.eof});
    endtask

    function automatic logic rdy_all();
        return (!en1 || if1.ready_o) && (!en2 || if2.ready_o) && (!en3 || if3.ready_o);
    endfunction

    function automatic int qsize(input int inst);
        if (inst == 1) return q1.size();
        if (inst == 3) return q3.size();
        return q2.size();
    endfunction

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic push(input logic [7:0] d, input logic s, e, f, g);
        int guard;
        guard = 0;
        din = d; s_i = s; e_i = e; f_i = f; g_i = g; vld = 1'b1;
        while (!rdy_all() && guard <= 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard > 500) begin
            chk("push ready timeout", 0, 1);
        end else begin
            @(negedge clk);
            acc_cyc = cyc - 1;
        end
        vld = 1'b0; s_i = 1'b0; e_i = 1'b0; f_i = 1'b0; g_i = 1'b0;
    endtask

    task automatic send_line(input logic [7:0] base, input logic sof, input logic eof);
        for (int i = 0; i < LL; i++)
            push(base + vin[i].d, vin[i].sop, vin[i].eop, sof && vin[i].sof, eof && vin[i].eof);
    endtask

    task automatic wait_out(input int inst, input int n, input string name);
        int g;
        g = 0;
        while (qsize(inst) < n && g < 400) begin
            @(negedge clk);
            g++;
        end
        repeat (6) @(negedge clk);
        chk(name, qsize(inst), n);
    endtask

    task automatic check_line2(input string name, input int off, input logic [7:0] base,
                               input logic sof, input logic eof);
        vec_t e;
        for (int k = 0; k < 4 * LL; k++) begin
            e = exp2[k];
            e.d = base + e.d;
            e.sof = e.sof && sof;
            e.eof = e.eof && eof;
            cmp_out($sformatf("%s[%0d]", name, k), q2[off + k], e);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global timeout: checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int first_acc;
        vec_t e;

        for (int i = 0; i < LL; i++) vin[i] = '{i[7:0], i == 0, i == LL - 1, i == 0, i == LL - 1};
        for (int k = 0; k < 4 * LL; k++)
            exp2[k] = '{rp[k % 16][7:0], (k % 16) == 0, (k % 16) == 15, k == 0, k == 31};

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset ready_o s2", if2.ready_o, 1);
        chk("reset ready_o s1/s3", {if1.ready_o, if3.ready_o}, 2'b11);
        chk("reset data_o", if2.data_o, 0);
        chk("reset valid/markers", {if2.data_valid_o, if2.sop_o, if2.eop_o, if2.sof_o,
                                    if2.eof_o}, 0);
`ifdef UP_SAMPLING_ERR_EN
        chk("reset err_o", err2, 0);
`endif

        // Single line with all markers
        q2.delete();
        send_line(8'h00, 1'b1, 1'b1);
        wait_out(2, 32, "line1 count");
        check_line2("line1", 0, 8'h00, 1'b1, 1'b1);
        chk("line1 latency", q2[0].cyc - acc_cyc, 3);
        chk("line1 contiguous", q2[31].cyc - q2[0].cyc, 31);

        // Back-to-back lines under continuous valid
        q2.delete();
        runs.delete();
        send_line(8'h10, 1'b1, 1'b0);
        first_acc = acc_cyc;
        send_line(8'h20, 1'b0, 1'b1);
        wait_out(2, 64, "b2b count");
        chk("b2b run count", runs.size() >= 2, 1);
        chk("b2b ready low 1", runs[0], 32);
        chk("b2b ready low 2", runs[1], 32);
        check_line2("b2b l1", 0, 8'h10, 1'b1, 1'b0);
        check_line2("b2b l2", 32, 8'h20, 1'b0, 1'b1);
        chk("b2b l1 latency", q2[0].cyc - first_acc, 3);
        chk("b2b l2 latency", q2[32].cyc - acc_cyc, 3);

        // sop_i reasserted at the 4th sample restarts the write
        q2.delete();
        push(8'h50, 1'b1, 1'b0, 1'b1, 1'b0);
        push(8'h51, 1'b0, 1'b0, 1'b0, 1'b0);
        push(8'h52, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < LL - 1; i++) push(8'h60 + i[7:0], i == 0, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("restart no early emit", q2.size(), 0);
        chk("restart still loading", if2.ready_o, 1);
        push(8'h67, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_out(2, 32, "restart count");
        check_line2("restart", 0, 8'h60, 1'b1, 1'b1);
        chk("restart latency", q2[0].cyc - acc_cyc, 3);
`ifdef UP_SAMPLING_ERR_EN
        chk("restart err_o", err2, 1);
`endif

        // Reset in the middle of emission
        send_line(8'h70, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset ready_o", if2.ready_o, 1);
        chk("midreset outputs", {if2.data_o, if2.data_valid_o, if2.sop_o, if2.eop_o,
                                 if2.sof_o, if2.eof_o}, 0);
        reset = 1'b0;
        q2.delete();
        send_line(8'h80, 1'b1, 1'b1);
        wait_out(2, 32, "postreset count");
        check_line2("postreset", 0, 8'h80, 1'b1, 1'b1);
`ifdef UP_SAMPLING_ERR_EN
        chk("postreset err_o", err2, 0);
`endif

        // SCALE=1 and SCALE=3 instances
        en2 = 1'b0; en1 = 1'b1; en3 = 1'b1;
        q1.delete();
        q3.delete();
        send_line(8'h00, 1'b1, 1'b1);
        wait_out(1, LL, "s1 count");
        wait_out(3, 9 * LL, "s3 count");
        for (int k = 0; k < LL; k++) begin
            e = '{k[7:0], k == 0, k == LL - 1, k == 0, k == LL - 1};
            cmp_out($sformatf("s1[%0d]", k), q1[k], e);
        end
        chk("s1 latency", q1[0].cyc - acc_cyc, 3);
        chk("s1 contiguous", q1[LL - 1].cyc - q1[0].cyc, LL - 1);
        for (int k = 0; k < 9 * LL; k++) begin
            int r;
            r = k % (3 * LL);
            e = '{8'((r / (3 * CH)) * CH + (r % CH)), r == 0, r == 3 * LL - 1,
                  k == 0, k == 9 * LL - 1};
            cmp_out($sformatf("s3[%0d]", k), q3[k], e);
        end
        chk("s3 latency", q3[0].cyc - acc_cyc, 3);
        chk("s3 contiguous", q3[9 * LL - 1].cyc - q3[0].cyc, 9 * LL - 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
